// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
// Shared definitions for the CPU-to-SRAM bridge: the access state machine
// encoding, default bus widths and the width of the wait-state counter.
// No ports; imported by cpu_mem_bridge and mem_wait_counter.
package cpu_mem_pkg;

    // Access sequencing: IDLE -> SETUP -> ACCESS (1 + wait states) -> DONE
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_W = 20;
    localparam int DEFAULT_DATA_W = 16;

    // Wide enough for wait-state settings 0..15
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter
// Loadable down-counter that paces the ACCESS phase of an SRAM cycle.
// Ports:
//   clk      - system clock
//   clr      - synchronous clear to zero (highest priority)
//   load     - load load_val this edge
//   load_val - value to load
//   dec      - decrement by one (saturates at zero)
//   zero     - high while the stored count is zero
module mem_wait_counter
    import cpu_mem_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; decrementing at zero holds zero so a stray
    // dec can never wrap the counter to its maximum.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge
// Converts level-style CPU memory requests into sequenced asynchronous
// SRAM cycles with a configurable number of wait states, returning
// registered read data and a one-cycle mem_ready pulse.
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   A, Data_out           - CPU address and write data
//   CE, OE, WE, UB, LB    - CPU strobes, active-low
//   Data_in               - registered read data (changes only on reads)
//   mem_ready             - one-cycle completion pulse
//   SRAM_ADDR, SRAM_DQ    - SRAM address and bidirectional data bus
//   SRAM_*_N              - SRAM strobes, active-low
//   rd_count, wr_count    - completed read/write counters (MEM_STATS_EN only)
// Build option: define MEM_STATS_EN to add the access statistics counters.
module cpu_mem_bridge
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] Data_out,
    input  logic              CE,
    input  logic              OE,
    input  logic              WE,
    input  logic              UB,
    input  logic              LB,
    output logic [DATA_W-1:0] Data_in,
    output logic              mem_ready,
`ifdef MEM_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    state_t              state_q, state_d;
    logic                armed_q, armed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ub_q, ub_d;
    logic                lb_q, lb_d;
    logic                is_write_q, is_write_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;

    logic                request;
    logic                rearm;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic                dq_oe;
    logic [WAIT_W-1:0]   wait_load_val;

    assign request       = !CE && (!OE || !WE);
    assign rearm         = CE || (OE && WE);
    assign wait_load_val = WAIT_W'(WAIT_STATES);

    mem_wait_counter #(
        .W (WAIT_W)
    ) u_wait_counter (
        .clk      (Clk),
        .clr      (Reset),
        .load     (cnt_load),
        .load_val (wait_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Next-state logic. A request is only accepted while armed; armed is
    // cleared on acceptance and set again once the CPU drops its strobes,
    // so a CPU holding OE/WE low past mem_ready gets exactly one access.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q || rearm;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ub_d       = ub_q;
        lb_d       = lb_q;
        is_write_d = is_write_q;
        data_in_d  = data_in_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        case (state_q)
            IDLE: begin
                if (armed_q && request) begin
                    addr_d     = A;
                    wdata_d    = Data_out;
                    ub_d       = UB;
                    lb_d       = LB;
                    is_write_d = !WE;
                    armed_d    = 1'b0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                cnt_load = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                // Last ACCESS cycle: capture the bus for reads and leave
                if (cnt_zero) begin
                    if (!is_write_q) begin
                        data_in_d = SRAM_DQ;
                    end
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // SRAM strobes decode straight from the state register. WE_N is held
    // high during SETUP so address and data settle before the write pulse.
    always_comb begin
        SRAM_CE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        SRAM_UB_N = 1'b1;
        SRAM_LB_N = 1'b1;
        dq_oe     = 1'b0;
        mem_ready = 1'b0;

        case (state_q)
            SETUP: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = is_write_q;
                SRAM_UB_N = ub_q;
                SRAM_LB_N = lb_q;
                dq_oe     = is_write_q;
            end
            ACCESS: begin
                SRAM_CE_N = 1'b0;
                SRAM_OE_N = is_write_q;
                SRAM_WE_N = !is_write_q;
                SRAM_UB_N = ub_q;
                SRAM_LB_N = lb_q;
                dq_oe     = is_write_q;
            end
            DONE: begin
                mem_ready = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign SRAM_ADDR = addr_q;
    assign SRAM_DQ   = dq_oe ? wdata_q : {DATA_W{1'bz}};
    assign Data_in   = data_in_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            armed_q    <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            ub_q       <= 1'b1;
            lb_q       <= 1'b1;
            is_write_q <= 1'b0;
            data_in_q  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ub_q       <= ub_d;
            lb_q       <= lb_d;
            is_write_q <= is_write_d;
            data_in_q  <= data_in_d;
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Count completed transfers in their DONE cycle; both wrap naturally
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == DONE) begin
            if (is_write_q) begin
                wr_count_d = wr_count_q + 16'd1;
            end else begin
                rd_count_d = rd_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge
// Self-checking bench for cpu_mem_bridge: a small behavioural SRAM on the
// pins, a word-array reference of memory contents and returned read data,
// a table of directed transfers, randomized transfers, and hand-written
// sequences for held strobes and reset during an access.
module tb_cpu_mem_bridge;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int WS = 2;
    localparam int LAST = WS + 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a;
    logic [DW-1:0] data_out;
    logic          ce, oe, we, ub, lb;

    wire  [DW-1:0] data_in;
    wire           mem_ready;
    wire  [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_dq;
    wire           sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
`ifdef MEM_STATS_EN
    wire  [15:0]   rd_count, wr_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] sram    [0:255];
    logic [15:0] ref_mem [0:255];
    logic [15:0] ref_data_in;
    int          rd_model = 0;
    int          wr_model = 0;

    typedef struct {
        bit          wr;
        bit          both;
        logic [19:0] addr;
        logic [15:0] data;
        bit          ub;
        bit          lb;
        logic [15:0] exp_din;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    cpu_mem_bridge #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_STATES (WS)
    ) dut (
        .Clk       (clk),
        .Reset     (reset),
        .A         (a),
        .Data_out  (data_out),
        .CE        (ce),
        .OE        (oe),
        .WE        (we),
        .UB        (ub),
        .LB        (lb),
        .Data_in   (data_in),
        .mem_ready (mem_ready),
`ifdef MEM_STATS_EN
        .rd_count  (rd_count),
        .wr_count  (wr_count),
`endif
        .SRAM_ADDR (sram_addr),
        .SRAM_DQ   (sram_dq),
        .SRAM_CE_N (sram_ce_n),
        .SRAM_OE_N (sram_oe_n),
        .SRAM_WE_N (sram_we_n),
        .SRAM_UB_N (sram_ub_n),
        .SRAM_LB_N (sram_lb_n)
    );

    // Behavioural asynchronous SRAM: drives the bus on reads, stores the
    // enabled bytes on each clock where the write strobe is low.
    wire model_drive = !sram_ce_n && !sram_oe_n && sram_we_n;
    assign sram_dq = model_drive ? sram[sram_addr[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) sram[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
            if (!sram_ub_n) sram[sram_addr[7:0]][15:8] <= sram_dq[15:8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Expected pin state k cycles after the request cycle
    task automatic checkCycle(input int k, input bit wr, input logic [19:0] addr,
                              input logic [15:0] data, input bit ubi, input bit lbi,
                              input logic [15:0] exp_din);
        bit active;
        bit acc;
        active = (k >= 1) && (k <= WS + 2);
        acc    = (k >= 2) && (k <= WS + 2);
        checkOutput($sformatf("ce_n k=%0d", k), 32'(sram_ce_n), 32'(!active));
        checkOutput($sformatf("oe_n k=%0d", k), 32'(sram_oe_n), 32'(!(active && !wr)));
        checkOutput($sformatf("we_n k=%0d", k), 32'(sram_we_n), 32'(!(acc && wr)));
        checkOutput($sformatf("ub_n k=%0d", k), 32'(sram_ub_n), 32'(active ? ubi : 1'b1));
        checkOutput($sformatf("lb_n k=%0d", k), 32'(sram_lb_n), 32'(active ? lbi : 1'b1));
        checkOutput($sformatf("dq_drive k=%0d", k), 32'(dut.dq_oe), 32'(active && wr));
        if (active) begin
            checkOutput($sformatf("addr k=%0d", k), 32'(sram_addr), 32'(addr));
        end
        if (active && wr) begin
            checkOutput($sformatf("dq k=%0d", k), 32'(sram_dq), 32'(data));
        end
        checkOutput($sformatf("mem_ready k=%0d", k), 32'(mem_ready), 32'(k == LAST));
        checkOutput($sformatf("data_in k=%0d", k), 32'(data_in), 32'(exp_din));
    endtask

    // One full transfer, starting just after a falling edge with the
    // bridge idle and armed. keep leaves the CPU strobes asserted.
    task automatic applyStimulus(input bit wr, input bit both, input logic [19:0] addr,
                                 input logic [15:0] data, input bit ubi, input bit lbi,
                                 input bit keep);
        logic [15:0] old_din;
        logic [15:0] new_din;
        a        = addr;
        data_out = data;
        ub       = ubi;
        lb       = lbi;
        ce       = 1'b0;
        we       = !wr;
        oe       = wr ? !both : 1'b0;
        old_din  = ref_data_in;
        new_din  = wr ? ref_data_in : ref_mem[addr[7:0]];
        for (int k = 1; k <= LAST; k++) begin
            @(negedge clk);
            checkCycle(k, wr, addr, data, ubi, lbi, (k == LAST) ? new_din : old_din);
        end
        if (wr) begin
            if (!lbi) ref_mem[addr[7:0]][7:0]  = data[7:0];
            if (!ubi) ref_mem[addr[7:0]][15:8] = data[15:8];
            wr_model++;
        end else begin
            rd_model++;
        end
        ref_data_in = new_din;
        if (!keep) begin
            ce = 1'b1;
            oe = 1'b1;
            we = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        int ready_cnt;
        int ce_low_cnt;

        for (int i = 0; i < 256; i++) begin
            sram[i]    = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        sram[8'h1F]    = 16'h2C07;
        ref_mem[8'h1F] = 16'h2C07;
        ref_data_in    = 16'h0000;

        tbl[0]  = '{1'b0, 1'b0, 20'h0001F, 16'h0000, 1'b0, 1'b0, 16'h2C07};
        tbl[1]  = '{1'b1, 1'b0, 20'h00010, 16'h3A07, 1'b0, 1'b0, 16'h2C07};
        tbl[2]  = '{1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 16'h3A07};
        tbl[3]  = '{1'b1, 1'b0, 20'h00010, 16'hFFFF, 1'b0, 1'b1, 16'h3A07};
        tbl[4]  = '{1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 16'hFF07};
        tbl[5]  = '{1'b1, 1'b0, 20'h00010, 16'h1234, 1'b1, 1'b1, 16'hFF07};
        tbl[6]  = '{1'b0, 1'b0, 20'h00010, 16'h0000, 1'b1, 1'b1, 16'hFF07};
        tbl[7]  = '{1'b1, 1'b0, 20'h00020, 16'hBEEF, 1'b1, 1'b0, 16'hFF07};
        tbl[8]  = '{1'b0, 1'b0, 20'h00020, 16'h0000, 1'b0, 1'b0, 16'h00EF};
        tbl[9]  = '{1'b1, 1'b1, 20'h00021, 16'h5555, 1'b0, 1'b0, 16'h00EF};
        tbl[10] = '{1'b0, 1'b0, 20'h00021, 16'h0000, 1'b0, 1'b0, 16'h5555};

        // Reset held with a pending read request
        reset = 1'b1; a = '0; data_out = '0;
        ce = 1'b0; oe = 1'b0; we = 1'b1; ub = 1'b0; lb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst mem_ready", 32'(mem_ready), 0);
            checkOutput("rst strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
            checkOutput("rst dq_drive", 32'(dut.dq_oe), 0);
            checkOutput("rst data_in", 32'(data_in), 0);
            checkOutput("rst addr", 32'(sram_addr), 0);
        end
        reset = 1'b0; ce = 1'b1; oe = 1'b1;
        @(negedge clk);

        // Directed transfers
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].wr, tbl[i].both, tbl[i].addr, tbl[i].data,
                          tbl[i].ub, tbl[i].lb, 1'b0);
            checkOutput($sformatf("table[%0d] data_in", i), 32'(data_in), 32'(tbl[i].exp_din));
        end

        // Held read strobe: one access only, then a fresh edge restarts
        applyStimulus(1'b0, 1'b0, 20'h0001F, 16'h0000, 1'b0, 1'b0, 1'b1);
        ready_cnt  = 0;
        ce_low_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ready_cnt  += int'(mem_ready);
            ce_low_cnt += int'(!sram_ce_n);
        end
        checkOutput("held extra mem_ready", 32'(ready_cnt), 0);
        checkOutput("held extra ce cycles", 32'(ce_low_cnt), 0);
        oe = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, 1'b0, 1'b0);

        // Randomized transfers against the reference model
        for (int i = 0; i < 24; i++) begin
            bit          rwr, rboth, rub, rlb;
            logic [19:0] raddr;
            logic [15:0] rdata;
            rwr   = 1'($urandom_range(0, 1));
            rboth = 1'($urandom_range(0, 1));
            rub   = ($urandom_range(0, 3) == 0);
            rlb   = ($urandom_range(0, 3) == 0);
            raddr = 20'($urandom_range(0, 254));
            rdata = 16'($urandom);
            applyStimulus(rwr, rboth, raddr, rdata, rub, rlb, 1'b0);
        end

`ifdef MEM_STATS_EN
        checkOutput("rd_count", 32'(rd_count), 32'(rd_model[15:0]));
        checkOutput("wr_count", 32'(wr_count), 32'(wr_model[15:0]));
`endif

        // Reset during the ACCESS phase of a write
        a = 20'h000FF; data_out = 16'h7777; ub = 1'b0; lb = 1'b0;
        ce = 1'b0; we = 1'b0; oe = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort pre we_n", 32'(sram_we_n), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort mem_ready", 32'(mem_ready), 0);
            checkOutput("abort strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}), 32'h1F);
            checkOutput("abort dq_drive", 32'(dut.dq_oe), 0);
            checkOutput("abort data_in", 32'(data_in), 0);
        end
        ce = 1'b1; we = 1'b1; reset = 1'b0;
        ref_data_in = 16'h0000;
        rd_model    = 0;
        wr_model    = 0;
        @(negedge clk);
`ifdef MEM_STATS_EN
        checkOutput("rd_count cleared", 32'(rd_count), 0);
        checkOutput("wr_count cleared", 32'(wr_count), 0);
`endif
        applyStimulus(1'b0, 1'b0, 20'h0001F, 16'h0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 20'h00030, 16'hA5C3, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 20'h00030, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("post-abort data_in", 32'(data_in), 32'h0000A5C3);
`ifdef MEM_STATS_EN
        checkOutput("rd_count after", 32'(rd_count), 2);
        checkOutput("wr_count after", 32'(wr_count), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
